// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation codes
// (the R-type funct values also used by the ALU control decoder), the FSM
// state encoding and the default operand width.
package mult_div_unit_pkg;

  localparam int unsigned DEF_WIDTH = 32;

  localparam logic [5:0] OP_MULT  = 6'd24;
  localparam logic [5:0] OP_MULTU = 6'd25;
  localparam logic [5:0] OP_DIV   = 6'd26;
  localparam logic [5:0] OP_DIVU  = 6'd27;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } md_state_e;

  function automatic logic is_md_op(input logic [5:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [5:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic is_mul_op(input logic [5:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

endpackage

// File: rtl/mult_div_unit_abs_neg.sv
// Conditional two's-complement negate. Used to take operand magnitudes on
// entry and to restore result signs in the FIX step.
module abs_neg
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] value_i,
  input  logic             negate_i,
  output logic [WIDTH-1:0] result_o
);

  // Negate when requested, otherwise pass through unchanged.
  always_comb begin
    result_o = negate_i ? (~value_i + WIDTH'(1)) : value_i;
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit. Shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, followed by a single sign-fix cycle.
// HI/LO hold the last completed result; busy/done form the stall handshake.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       operation,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned AW = 2 * WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Shared accumulator. MUL: {carry, partial product, multiplier}.
  // DIV: {unused, partial remainder, dividend/quotient}.
  logic [AW-1:0]    acc_q, acc_d;
  // Multiplicand magnitude (MUL) or divisor magnitude (DIV).
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             is_mul_q, is_mul_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             op_valid, op_signed, op_mul, b_zero;
  logic [WIDTH-1:0] a_mag, b_mag;

  logic [WIDTH-1:0] mul_addend;
  logic [WIDTH:0]   mul_sum;
  logic [AW-1:0]    mul_step;

  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_trial;
  logic             div_ok;
  logic [WIDTH-1:0] div_rem;
  logic [AW-1:0]    div_step;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Decode the requested operation.
  always_comb begin
    op_valid  = is_md_op(operation);
    op_signed = is_signed_op(operation);
    op_mul    = is_mul_op(operation);
    b_zero    = (b == '0);
  end

  abs_neg #(.WIDTH(WIDTH)) u_abs_a (
    .value_i  (a),
    .negate_i (op_signed & a[WIDTH-1]),
    .result_o (a_mag)
  );

  abs_neg #(.WIDTH(WIDTH)) u_abs_b (
    .value_i  (b),
    .negate_i (op_signed & b[WIDTH-1]),
    .result_o (b_mag)
  );

  // One shift-add multiply step: add multiplicand if the current multiplier
  // bit is set, then shift the whole accumulator right by one.
  always_comb begin
    mul_addend = acc_q[0] ? opnd_q : '0;
    mul_sum    = {acc_q[AW-1], acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
    mul_step   = {1'b0, mul_sum, acc_q[WIDTH-1:1]};
  end

  // One restoring divide step: shift in the next dividend bit, trial-subtract
  // the divisor, keep the difference only when it did not borrow.
  always_comb begin
    div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    div_trial = {1'b0, div_shift} - {2'b00, opnd_q};
    div_ok    = ~div_trial[WIDTH+1];
    div_rem   = div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_step  = {1'b0, div_rem, acc_q[WIDTH-2:0], div_ok};
  end

  abs_neg #(.WIDTH(2 * WIDTH)) u_fix_prod (
    .value_i  (acc_q[2*WIDTH-1:0]),
    .negate_i (neg_res_q),
    .result_o (prod_fix)
  );

  abs_neg #(.WIDTH(WIDTH)) u_fix_quo (
    .value_i  (acc_q[WIDTH-1:0]),
    .negate_i (neg_res_q),
    .result_o (quo_fix)
  );

  abs_neg #(.WIDTH(WIDTH)) u_fix_rem (
    .value_i  (acc_q[2*WIDTH-1:WIDTH]),
    .negate_i (neg_rem_q),
    .result_o (rem_fix)
  );

  // Next-state, datapath update and handshake outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    is_mul_d  = is_mul_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy      = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start && op_valid) begin
          is_mul_d  = op_mul;
          neg_res_d = op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_rem_d = op_signed & a[WIDTH-1];
          cnt_d     = '0;
          if (op_mul) begin
            opnd_d  = a_mag;
            acc_d   = {1'b0, {WIDTH{1'b0}}, b_mag};
            state_d = S_MUL;
          end else if (b_zero) begin
            // Divide by zero completes immediately with a fixed result.
            hi_d    = a;
            lo_d    = '1;
            state_d = S_DONE;
          end else begin
            opnd_d  = b_mag;
            acc_d   = {1'b0, {WIDTH{1'b0}}, a_mag};
            state_d = S_DIV;
          end
        end
      end
      S_MUL: begin
        busy  = 1'b1;
        acc_d = mul_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) state_d = S_FIX;
      end
      S_DIV: begin
        busy  = 1'b1;
        acc_d = div_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) state_d = S_FIX;
      end
      S_FIX: begin
        busy  = 1'b1;
        cnt_d = '0;
        if (is_mul_q) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      is_mul_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      is_mul_q  <= is_mul_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule
